// File: rtl/melody_sequencer.sv
// Song ROM player: walks {note,dur} entries and drives the note code with tempo and inter-note gaps.
// Optional PAUSE_EN macro adds pause_i, which freezes timing and silences the note while playing.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs quiet
// S_FETCH | ROM address presented, waiting one cycle for read data
// S_LOAD  | entry captured: end marker, loop restart, or note load
// S_PLAY  | note held for dur tempo ticks
// S_GAP   | silent articulation gap before the next entry
module melody_sequencer #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_250_000,
  parameter int ADDR_W     = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_en_i,
`ifdef PAUSE_EN
  input  logic              pause_i,
`endif
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [3:0]        note_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0]     TICK_ONE  = TW'(1);
  localparam logic [GW-1:0]     GAP_ONE   = GW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state_q;
  logic [TW-1:0]     tick_cnt_q;
  logic [3:0]        dur_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [3:0]        note_q;
  logic              busy_q;
  logic              done_q;
  logic              frozen;
  logic [3:0]        dur;

  assign dur = rom_data_i[3:0];

`ifdef PAUSE_EN
  assign frozen = pause_i && ((state_q == S_PLAY) || (state_q == S_GAP));
  // Silencing must be immediate while paused, so it bypasses the note register.
  assign note_o = frozen ? 4'd0 : note_q;
`else
  assign frozen = 1'b0;
  assign note_o = note_q;
`endif

  assign rom_addr_o = rom_addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rom_addr_q <= '0;
      note_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        tick_cnt_q <= '0;
        dur_cnt_q  <= '0;
        gap_cnt_q  <= '0;
        rom_addr_q <= '0;
        note_q     <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              rom_addr_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            if (dur == 4'd0) begin
              // A marker at address 0 always ends, otherwise an empty looped song spins forever.
              if (loop_en_i && (rom_addr_q != '0)) begin
                rom_addr_q <= '0;
                state_q    <= S_FETCH;
              end else begin
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                rom_addr_q <= '0;
                state_q    <= S_IDLE;
              end
            end else begin
              note_q     <= rom_data_i[7:4];
              tick_cnt_q <= '0;
              dur_cnt_q  <= dur;
              state_q    <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!frozen) begin
              if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_q <= '0;
                dur_cnt_q  <= dur_cnt_q - 4'd1;
                if (dur_cnt_q == 4'd1) begin
                  note_q <= '0;
                  if (GAP_CYCLES != 0) begin
                    gap_cnt_q <= '0;
                    state_q   <= S_GAP;
                  end else begin
                    rom_addr_q <= rom_addr_q + ADDR_ONE;
                    state_q    <= S_FETCH;
                  end
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + TICK_ONE;
              end
            end
          end
          S_GAP: begin
            if (!frozen) begin
              if (gap_cnt_q == GAP_LAST) begin
                gap_cnt_q  <= '0;
                rom_addr_q <= rom_addr_q + ADDR_ONE;
                state_q    <= S_FETCH;
              end else begin
                gap_cnt_q <= gap_cnt_q + GAP_ONE;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: builds an expected per-cycle timeline from the song rules
// (fetch, load, dur*tick note, gap) and compares note/busy/done/rom_addr every cycle.
module tb_melody_sequencer;

  localparam int TD  = 4;
  localparam int GAP = 2;
  localparam int AW  = 3;
  localparam int N   = 160;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, loop_en;
  logic          pause;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [3:0]    note;
  logic          busy, done;

  logic [7:0] rom [8];

  int exp_note [N];
  int exp_addr [N];
  bit exp_busy [N];
  bit exp_done [N];
  bit drv_start [N];
  bit drv_stop [N];

  int n_checks = 0;
  int n_fail   = 0;

  melody_sequencer #(.TICK_DIV(TD), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .loop_en_i  (loop_en),
`ifdef PAUSE_EN
    .pause_i    (pause),
`endif
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .note_o     (note),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic void put(int c, int n, bit b, bit d, int a);
    if (c >= 0 && c < N) begin
      exp_note[c] = n;
      exp_busy[c] = b;
      exp_done[c] = d;
      exp_addr[c] = a;
    end
  endfunction

  function automatic void clear_model();
    for (int c = 0; c < N; c++) begin
      exp_note[c] = 0; exp_addr[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
      drv_start[c] = 0; drv_stop[c] = 0;
    end
  endfunction

  // Song walk: start at s, then per entry FETCH + LOAD, note for dur*TD, GAP silent cycles.
  function automatic void build(int s, bit lp);
    int t, addr, len, n, d;
    logic [7:0] e;
    t = s + 1;
    addr = 0;
    drv_start[s] = 1;
    while (t < N) begin
      e = rom[addr];
      n = int'(e[7:4]);
      d = int'(e[3:0]);
      put(t, 0, 1, 0, addr);
      put(t + 1, 0, 1, 0, addr);
      if (d == 0) begin
        if (lp && addr != 0) begin
          addr = 0;
          t = t + 2;
        end else begin
          put(t + 2, 0, 0, 1, 0);
          break;
        end
      end else begin
        len = d * TD;
        for (int i = 0; i < len; i++) put(t + 2 + i, n, 1, 0, addr);
        for (int i = 0; i < GAP; i++) put(t + 2 + len + i, 0, 1, 0, addr);
        t = t + 2 + len + GAP;
        addr = (addr + 1) % 8;
      end
    end
  endfunction

  function automatic void apply_stop(int k);
    drv_stop[k] = 1;
    for (int c = k + 1; c < N; c++) begin
      exp_note[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_addr[c] = 0;
    end
  endfunction

  function automatic void add_busy_starts(int cnt);
    int c;
    for (int i = 0; i < cnt; i++) begin
      c = int'($urandom_range(0, N - 1));
      if (exp_busy[c]) drv_start[c] = 1;
    end
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input string name, input bit lp);
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      n_checks += 3;
      if (note !== 4'(exp_note[c])) begin
        n_fail++;
        $display("FAIL %s note cycle %0d: got %0d expected %0d", name, c, note, exp_note[c]);
      end
      if (busy !== exp_busy[c]) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %0b expected %0b", name, c, busy, exp_busy[c]);
      end
      if (done !== exp_done[c]) begin
        n_fail++;
        $display("FAIL %s done cycle %0d: got %0b expected %0b", name, c, done, exp_done[c]);
      end
      if (exp_busy[c]) begin
        n_checks++;
        if (rom_addr !== AW'(exp_addr[c])) begin
          n_fail++;
          $display("FAIL %s rom_addr cycle %0d: got %0d expected %0d", name, c, rom_addr, exp_addr[c]);
        end
      end
      start   = drv_start[c];
      stop    = drv_stop[c];
      loop_en = lp;
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic load_song3();
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
    rom[0] = 8'h13; rom[1] = 8'hA2; rom[2] = 8'h00;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    n_checks++;
    if ({note, busy, done, rom_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got note=%0d busy=%0b done=%0b addr=%0d expected all 0",
               note, busy, done, rom_addr);
    end
  endtask

  task automatic test_song();
    reset_dut(); load_song3(); clear_model();
    build(0, 0);
    run("song", 0);
  endtask

  task automatic test_loop();
    reset_dut(); load_song3(); clear_model();
    build(0, 1);
    run("loop", 1);
  endtask

  task automatic test_empty_loop();
    reset_dut(); clear_model();
    for (int i = 0; i < 8; i++) rom[i] = 8'h31;
    rom[0] = 8'h00;
    build(0, 1);
    run("empty_loop", 1);
  endtask

  task automatic test_wrap();
    reset_dut(); clear_model();
    for (int i = 0; i < 8; i++) rom[i] = 8'h51;
    build(2, 0);
    run("wrap", 0);
  endtask

  task automatic test_stop_restart();
    reset_dut(); load_song3(); clear_model();
    build(0, 0);
    apply_stop(8);
    build(20, 0);
    drv_start[25] = 1;
    drv_start[33] = 1;
    run("stop_restart", 0);
  endtask

  task automatic test_async_reset();
    reset_dut(); load_song3();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (note !== 4'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset pre: got note=%0d busy=%0b expected note=1 busy=1", note, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({note, busy, done, rom_addr} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got note=%0d busy=%0b done=%0b addr=%0d expected all 0",
               note, busy, done, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int s, k;
    bit lp;
    for (int it = 0; it < 12; it++) begin
      reset_dut(); clear_model();
      for (int i = 0; i < 8; i++) begin
        rom[i][7:4] = 4'($urandom_range(0, 15));
        rom[i][3:0] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      end
      lp = 1'($urandom_range(0, 1));
      s  = int'($urandom_range(0, 5));
      build(s, lp);
      if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(s + 1, N - 20));
        apply_stop(k);
      end
      add_busy_starts(4);
      run("random", lp);
    end
  endtask

  initial begin
    rom_data = 8'h00;
    test_reset();
    test_song();
    test_loop();
    test_empty_loop();
    test_wrap();
    test_stop_restart();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
